// File: rtl/seg_msg_ctrl_pkg.sv
// Shared definitions for the segment message controller: character codes,
// segment-byte constants, controller states and the digit glyph helper.
package seg_msg_ctrl_pkg;

  // Character codes delivered by the Morse decoder
  localparam logic [5:0] CH_A     = 6'd0;
  localparam logic [5:0] CH_0     = 6'd26;
  localparam logic [5:0] CH_BLANK = 6'd36;
  localparam logic [5:0] CH_ERR   = 6'd37;

  // Segment byte layout: bit7 = a ... bit1 = g, bit0 = dp, 1 = lit
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ERR   = 8'h02;
  localparam logic [7:0] SEG_DP    = 8'h01;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Glyphs for the decimal digits 0-9
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0: s = 8'hFC;
      4'd1: s = 8'h60;
      4'd2: s = 8'hDA;
      4'd3: s = 8'hF2;
      4'd4: s = 8'h66;
      4'd5: s = 8'hB6;
      4'd6: s = 8'hBE;
      4'd7: s = 8'hE0;
      4'd8: s = 8'hFE;
      4'd9: s = 8'hF6;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_char_enc.sv
// Combinational character-code to 7-segment ROM, one instance per digit.
// The dp bit is always left dark here; the cursor is merged in by the top.
module seg_char_enc
  import seg_msg_ctrl_pkg::*;
(
  input  logic [5:0] code,
  output logic [7:0] seg
);

  // Look up the glyph: digits via the shared helper, letters via the table
  always_comb begin
    seg = SEG_BLANK;
    if (code >= CH_0 && code <= CH_0 + 6'd9) begin
      seg = digit_seg(4'(code - CH_0));
    end else begin
      case (code)
        CH_A:   seg = 8'hEE;
        6'd1:   seg = 8'h3E;
        6'd2:   seg = 8'h9C;
        6'd3:   seg = 8'h7A;
        6'd4:   seg = 8'h9E;
        6'd5:   seg = 8'h8E;
        6'd6:   seg = 8'hBC;
        6'd7:   seg = 8'h6E;
        6'd8:   seg = 8'h0C;
        6'd9:   seg = 8'h78;
        6'd10:  seg = 8'hAE;
        6'd11:  seg = 8'h1C;
        6'd12:  seg = 8'hA8;
        6'd13:  seg = 8'h2A;
        6'd14:  seg = 8'h3A;
        6'd15:  seg = 8'hCE;
        6'd16:  seg = 8'hE6;
        6'd17:  seg = 8'h0A;
        6'd18:  seg = 8'hB6;
        6'd19:  seg = 8'h1E;
        6'd20:  seg = 8'h7C;
        6'd21:  seg = 8'h38;
        6'd22:  seg = 8'h54;
        6'd23:  seg = 8'h6E;
        6'd24:  seg = 8'h76;
        6'd25:  seg = 8'hDA;
        CH_ERR: seg = SEG_ERR;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_msg_ctrl.sv
// Display-buffer controller: keeps an 8-character scrolling line fed by the
// Morse decoder, handles clear/backspace, blinks a cursor and drives the
// registered 64-bit segment word for the digit scanner.
module seg_msg_ctrl
  import seg_msg_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CHAR_W     = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic                    char_valid,
  input  logic [CHAR_W-1:0]       char_code,
  output logic                    char_ready,
  input  logic                    cmd_clr,
  input  logic                    cmd_bksp,
  input  logic                    cursor_en,
  output logic [8*NUM_DIGITS-1:0] seg_data,
  output logic [3:0]              char_count,
  output logic                    busy
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    FULL      = 4'(NUM_DIGITS);

  state_t              state, state_next;
  logic [CHAR_W-1:0]   line [NUM_DIGITS];
  logic [IW-1:0]       clr_idx;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic                do_clr_start, do_bksp, do_accept;
  logic                cursor_on;
  logic [7:0]          cursor_byte;
  logic [8*NUM_DIGITS-1:0] enc_word;

  // State register
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and the single action chosen this cycle (clr > bksp > char)
  always_comb begin
    state_next   = state;
    do_clr_start = 1'b0;
    do_bksp      = 1'b0;
    do_accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_clr) begin
          state_next   = ST_CLEAR;
          do_clr_start = 1'b1;
        end else if (cmd_bksp) begin
          do_bksp = (char_count != 4'd0);
        end else if (char_valid) begin
          do_accept = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_idx == LAST_IDX) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign char_ready = (state == ST_IDLE) && !cmd_clr && !cmd_bksp;
  assign busy       = (state == ST_CLEAR);

  // Character line, count and clear sweep pointer; slot 0 holds the newest
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) line[i] <= CHAR_W'(CH_BLANK);
      char_count <= 4'd0;
      clr_idx    <= '0;
    end else if (state == ST_CLEAR) begin
      line[clr_idx] <= CHAR_W'(CH_BLANK);
      clr_idx       <= (clr_idx == LAST_IDX) ? '0 : clr_idx + IW'(1);
    end else if (do_clr_start) begin
      char_count <= 4'd0;
      clr_idx    <= '0;
    end else if (do_bksp) begin
      for (int i = 0; i < NUM_DIGITS - 1; i++) line[i] <= line[i+1];
      line[NUM_DIGITS-1] <= CHAR_W'(CH_BLANK);
      char_count <= char_count - 4'd1;
    end else if (do_accept) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) line[i] <= line[i-1];
      line[0] <= char_code;
      if (char_count != FULL) char_count <= char_count + 4'd1;
    end
  end

  // Cursor blink timebase: phase flips each BLINK_DIV cycles
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_TOP) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_enc
      seg_char_enc u_enc (
        .code (line[g]),
        .seg  (enc_word[8*g +: 8])
      );
    end
  endgenerate

  assign cursor_on   = cursor_en && blink_phase && (char_count < FULL);
  assign cursor_byte = cursor_on ? SEG_DP : SEG_BLANK;

  // Output register: glyphs plus the cursor dot on the rightmost digit
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) seg_data <= '0;
    else     seg_data <= enc_word | {{(8*NUM_DIGITS-8){1'b0}}, cursor_byte};
  end

endmodule
